csc_dual_group_ctrl: RTL and testbench

- Ping-pong layer sequencer for the CSC dual register groups (group 0, group 1).
- Tracks per-group op_en, selects the group the datapath executes, and issues the launch to the datapath.
- Retires the executing group on datapath completion.
- Produces the consumer pointer and 2-bit per-group status consumed by the single-register file, plus per-group done interrupts.

---
 rtl/csc_dual_group_ctrl.sv | 156 +++++++++++++++
 tb/tb_csc_dual_group_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/csc_dual_group_ctrl.sv
// -----------------------------------------------------------------------------
// csc_dual_group_ctrl
//
// Ping-pong layer sequencer for the two CSC register groups. Software arms a
// group by pulsing op_en_wr_g; the sequencer launches the group named by the
// consumer pointer (strict alternation 0,1,0,...), holds dp_op_en while the
// datapath runs it, and retires it on dp_done by clearing its op_en, toggling
// the consumer pointer and pulsing that group's done interrupt.
//
// Ports
//   nvdla_core_clk     in   core clock
//   nvdla_core_rstn    in   asynchronous active-low reset
//   op_en_wr_0/1       in   1-cycle pulse: software sets op_en of group 0/1
//   dp_done            in   1-cycle pulse: datapath finished the running layer
//   dp_op_en           out  high while the datapath runs group dp_group
//   dp_group           out  group the datapath executes (= consumer)
//   consumer           out  consumer pointer for the register file
//   status_0/1         out  group status: 0 idle, 1 running, 2 pending
//   intr_done[1:0]     out  1-cycle pulse per group on retirement
//   err_dup_wr         out  1-cycle pulse: op_en write to an enabled group
//   err_spurious_done  out  1-cycle pulse: dp_done while not running
//
// Handshake: there is no back-pressure. op_en_wr_g and dp_done are sampled on
// every rising edge and each high cycle counts as one event; dp_op_en is a
// level that stays high from launch until the cycle after dp_done is sampled.
// -----------------------------------------------------------------------------
module csc_dual_group_ctrl #(
  parameter int unsigned LAUNCH_GAP = 4,
  parameter int unsigned GAP_W      = 8
) (
  input  logic       nvdla_core_clk,
  input  logic       nvdla_core_rstn,
  input  logic       op_en_wr_0,
  input  logic       op_en_wr_1,
  input  logic       dp_done,
  output logic       dp_op_en,
  output logic       dp_group,
  output logic       consumer,
  output logic [1:0] status_0,
  output logic [1:0] status_1,
  output logic [1:0] intr_done,
  output logic       err_dup_wr,
  output logic       err_spurious_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Count loaded on IDLE exit; the GAP state is left when the count would
  // decrement to zero, so the first RUN cycle lands LAUNCH_GAP cycles after
  // the first IDLE cycle that sees the consumer group enabled.
  localparam logic [GAP_W-1:0] GAP_LOAD =
    GAP_W'((LAUNCH_GAP > 0) ? (LAUNCH_GAP - 1) : 0);
  localparam bit DIRECT_RUN = (LAUNCH_GAP <= 1);

  state_t           state_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [1:0]       op_en_q;
  logic [1:0]       op_en_d;
  logic             consumer_q;
  logic             dp_op_en_q;
  logic [1:0]       intr_done_q;
  logic             err_dup_wr_q;
  logic             err_spurious_q;

  logic [1:0] wr_vec;
  logic       retire;
  logic [1:0] retire_vec;
  logic [1:0] dup_vec;

  always_comb begin
    wr_vec     = {op_en_wr_1, op_en_wr_0};
    retire     = (state_q == ST_RUN) && dp_done;
    retire_vec = 2'b00;
    if (retire) begin
      retire_vec = consumer_q ? 2'b10 : 2'b01;
    end
    // A write to the group being retired re-arms it instead of being an error.
    dup_vec = wr_vec & op_en_q & ~retire_vec;
    op_en_d = (op_en_q & ~retire_vec) | wr_vec;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q        <= ST_IDLE;
      gap_cnt_q      <= '0;
      op_en_q        <= 2'b00;
      consumer_q     <= 1'b0;
      dp_op_en_q     <= 1'b0;
      intr_done_q    <= 2'b00;
      err_dup_wr_q   <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      op_en_q        <= op_en_d;
      intr_done_q    <= retire_vec;
      err_dup_wr_q   <= |dup_vec;
      err_spurious_q <= dp_done && (state_q != ST_RUN);
      case (state_q)
        ST_IDLE: begin
          if (op_en_q[consumer_q]) begin
            if (DIRECT_RUN) begin
              state_q    <= ST_RUN;
              dp_op_en_q <= 1'b1;
            end else begin
              state_q   <= ST_GAP;
              gap_cnt_q <= GAP_LOAD;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q <= GAP_W'(1)) begin
            state_q    <= ST_RUN;
            gap_cnt_q  <= '0;
            dp_op_en_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        ST_RUN: begin
          if (dp_done) begin
            state_q    <= ST_IDLE;
            consumer_q <= ~consumer_q;
            dp_op_en_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          dp_op_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Status decodes straight from registers: enabled + consumer + launched.
  always_comb begin
    status_0 = 2'd0;
    status_1 = 2'd0;
    if (op_en_q[0]) begin
      status_0 = (!consumer_q && (state_q != ST_IDLE)) ? 2'd1 : 2'd2;
    end
    if (op_en_q[1]) begin
      status_1 = (consumer_q && (state_q != ST_IDLE)) ? 2'd1 : 2'd2;
    end
  end

  assign dp_op_en          = dp_op_en_q;
  assign dp_group          = consumer_q;
  assign consumer          = consumer_q;
  assign intr_done         = intr_done_q;
  assign err_dup_wr        = err_dup_wr_q;
  assign err_spurious_done = err_spurious_q;

endmodule

// File: tb/tb_csc_dual_group_ctrl.sv
module tb_csc_dual_group_ctrl;

  localparam int L = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic w0 = 1'b0, w1 = 1'b0, dpd = 1'b0;
  logic       dp_op_en, dp_group, consumer;
  logic [1:0] status_0, status_1, intr_done;
  logic       err_dup_wr, err_spurious_done;

  csc_dual_group_ctrl #(.LAUNCH_GAP(L), .GAP_W(8)) dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rstn  (rstn),
    .op_en_wr_0       (w0),
    .op_en_wr_1       (w1),
    .dp_done          (dpd),
    .dp_op_en         (dp_op_en),
    .dp_group         (dp_group),
    .consumer         (consumer),
    .status_0         (status_0),
    .status_1         (status_1),
    .intr_done        (intr_done),
    .err_dup_wr       (err_dup_wr),
    .err_spurious_done(err_spurious_done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Groups are armed flags; the consumer group is launched L cycles after it
  // is first seen armed while nothing is in flight; launch_wait counts down
  // the remaining cycles before the datapath is considered running.
  bit       m_op [2];
  bit       m_cons;
  bit       m_run;
  int       m_wait;
  bit [1:0] m_intr;
  bit       m_dup, m_spur;
  bit       ret, start;
  bit [1:0] wr;

  initial begin
    m_op[0] = 0; m_op[1] = 0; m_cons = 0; m_run = 0; m_wait = 0;
    m_intr = 0; m_dup = 0; m_spur = 0;
  end

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_op[0] = 0; m_op[1] = 0; m_cons = 0; m_run = 0; m_wait = 0;
      m_intr = 0; m_dup = 0; m_spur = 0;
    end else begin
      wr     = {w1, w0};
      ret    = m_run && dpd;
      m_spur = dpd && !m_run;
      m_dup  = 0;
      m_intr = 0;
      start  = !m_run && (m_wait == 0) && m_op[m_cons];
      for (int g = 0; g < 2; g++) begin
        bit retiring_g;
        retiring_g = ret && (int'(m_cons) == g);
        if (wr[g] && m_op[g] && !retiring_g) m_dup = 1;
        m_op[g] = (m_op[g] && !retiring_g) || wr[g];
      end
      if (ret) begin
        m_intr[m_cons] = 1'b1;
        m_cons = ~m_cons;
        m_run  = 0;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_run = 1;
      end else if (start) begin
        if (L <= 1) m_run = 1;
        else m_wait = L - 1;
      end
    end
  end

  function automatic logic [1:0] m_status(input int g);
    if (!m_op[g]) return 2'd0;
    if ((int'(m_cons) == g) && (m_run || m_wait > 0)) return 2'd1;
    return 2'd2;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("dp_op_en",   {7'd0, dp_op_en},          {7'd0, m_run});
      chk("dp_group",   {7'd0, dp_group},          {7'd0, m_cons});
      chk("consumer",   {7'd0, consumer},          {7'd0, m_cons});
      chk("status_0",   {6'd0, status_0},          {6'd0, m_status(0)});
      chk("status_1",   {6'd0, status_1},          {6'd0, m_status(1)});
      chk("intr_done",  {6'd0, intr_done},         {6'd0, m_intr});
      chk("err_dup",    {7'd0, err_dup_wr},        {7'd0, m_dup});
      chk("err_spur",   {7'd0, err_spurious_done}, {7'd0, m_spur});
    end
  end

  // ---------------- driver tasks ----------------
  // One cycle with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic a0, input logic a1, input logic d);
    w0 = a0; w1 = a1; dpd = d;
    @(posedge clk);
    #1;
    w0 = 1'b0; w1 = 1'b0; dpd = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rst_outs"},
        {dp_op_en, dp_group, consumer, intr_done, err_dup_wr, err_spurious_done, 1'b0}, 8'd0);
    chk({tag, "_rst_status"}, {4'd0, status_1, status_0}, 8'd0);
  endtask

  // Asynchronous reset applied and released away from clock edges.
  task automatic do_reset(input string tag);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero(tag);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #3;
    chk_en = 1'b1;
    do_reset("init");

    // Basic launch / retire of group 0, group 1 armed during the run.
    step(1, 0, 0);                              // cycle 0
    chk("c1_status_0", {6'd0, status_0}, 8'd2);
    chk("c1_dp_op_en", {7'd0, dp_op_en}, 8'd0);
    idle(3);                                    // now cycle 4
    chk("c4_dp_op_en", {7'd0, dp_op_en}, 8'd0);
    idle(1);                                    // cycle 5
    chk("c5_dp_op_en", {7'd0, dp_op_en}, 8'd1);
    chk("c5_status_0", {6'd0, status_0}, 8'd1);
    step(0, 1, 0);                              // cycle 5 -> 6
    chk("c6_status_1", {6'd0, status_1}, 8'd2);
    idle(4);                                    // cycle 10
    step(0, 0, 1);                              // dp_done at 10
    chk("c11_intr",     {6'd0, intr_done}, 8'd1);
    chk("c11_consumer", {7'd0, consumer},  8'd1);
    chk("c11_status_0", {6'd0, status_0},  8'd0);
    chk("c11_dp_op_en", {7'd0, dp_op_en},  8'd0);
    idle(3);                                    // cycle 14
    chk("g1_early", {7'd0, dp_op_en}, 8'd0);
    idle(1);                                    // cycle 15
    chk("g1_launch",   {7'd0, dp_op_en}, 8'd1);
    chk("g1_dp_group", {7'd0, dp_group}, 8'd1);
    chk("g1_status_1", {6'd0, status_1}, 8'd1);
    step(0, 0, 1);
    chk("g1_intr",     {6'd0, intr_done}, 8'd2);
    chk("g1_consumer", {7'd0, consumer},  8'd0);

    // Only group 1 armed while consumer=0: must not launch.
    step(0, 1, 0);
    idle(12);
    chk("nc_no_launch", {7'd0, dp_op_en}, 8'd0);
    chk("nc_status_1",  {6'd0, status_1}, 8'd2);
    step(1, 0, 0);
    step(1, 0, 0);                              // duplicate write
    chk("dup_err", {7'd0, err_dup_wr}, 8'd1);
    idle(3);
    chk("nc_g0_first", {7'd0, dp_op_en}, 8'd1);
    chk("nc_g0_group", {7'd0, dp_group}, 8'd0);

    // Same-cycle dp_done and re-arm of the retiring group.
    step(1, 0, 1);
    chk("rearm_intr",     {6'd0, intr_done},  8'd1);
    chk("rearm_consumer", {7'd0, consumer},   8'd1);
    chk("rearm_err",      {7'd0, err_dup_wr}, 8'd0);
    chk("rearm_status_0", {6'd0, status_0},   8'd2);
    idle(4);
    chk("rearm_g1_run", {7'd0, dp_group & dp_op_en}, 8'd1);
    chk("rearm_g0_wait", {6'd0, status_0}, 8'd2);
    step(0, 0, 1);
    chk("rearm_back_0", {7'd0, consumer}, 8'd0);

    // Spurious done in IDLE.
    do_reset("pre_spur");
    step(0, 0, 1);
    chk("spur_err", {7'd0, err_spurious_done}, 8'd1);
    chk("spur_run", {7'd0, dp_op_en}, 8'd0);

    // Reset mid-GAP and mid-RUN.
    step(1, 0, 0);
    idle(2);
    do_reset("mid_gap");
    idle(8);
    chk("post_gap_idle", {7'd0, dp_op_en}, 8'd0);
    step(1, 1, 0);
    idle(6);
    chk("pre_run_rst", {7'd0, dp_op_en}, 8'd1);
    do_reset("mid_run");
    idle(8);
    chk("post_run_idle", {7'd0, dp_op_en}, 8'd0);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset("rand");
      end else begin
        step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 3) == 0);
      end
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
